coin_pulse_conditioner: RTL and testbench
=========================================

Name: coin_pulse_conditioner

Overview:
- Sits directly upstream of the Moore cola vending FSM.
- Converts raw, asynchronous, bouncy coin-sensor lines (1-yuan and 0.5-yuan slots) into clean, single-cycle, mutually exclusive piOne/piHalf pulses in the sys_clk domain.
- Serializes coins that arrive together, flags lost coins, and keeps per-denomination coin counts for audit.

Parameters:
DEB_CYCLES, 4, consecutive cycles a synchronized input must differ from its debounced level before that level flips; legal range 1..15
CNT_W, 8, width of the coin audit counters

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sysRstN  input  1  reset, asynchronous, active-low
coin_one_raw  input  1  raw 1-yuan sensor, asynchronous, may bounce
coin_half_raw  input  1  raw 0.5-yuan sensor, asynchronous, may bounce
piOne  output  1  one-cycle pulse per accepted 1-yuan coin, registered
piHalf  output  1  one-cycle pulse per accepted 0.5-yuan coin, registered
coin_err  output  1  one-cycle pulse when a coin is dropped (pending overflow), registered
one_cnt  output  CNT_W  count of emitted piOne pulses
half_cnt  output  CNT_W  count of emitted piHalf pulses

Behaviour:
- Reset (async, sysRstN=0): all registers clear immediately. piOne=piHalf=coin_err=0, counters=0, FSM=IDLE, pending flags=0, sync/debounce levels=0. Assertion mid-operation discards any pending or in-flight coin.
- Synchronizer: 2-flop chain per raw input (s1, s2), both reset to 0.
- Debounce, per channel. Holds a level deb (reset 0) and a counter dcnt (reset 0).
  - On each edge where s2 != deb: if dcnt == DEB_CYCLES-1, then deb <= s2 and dcnt <= 0; otherwise dcnt++.
  - On each edge where s2 == deb: dcnt <= 0.
  - Rising and falling transitions are filtered identically. A raw pulse held for fewer than DEB_CYCLES cycles never changes deb.
- Pending flag, per channel (pend_one, pend_half):
  - Set on the edge where deb goes 0->1.
  - Cleared on the edge where the FSM enters the matching EMIT state.
  - If set and clear occur on the same edge, set wins.
- Overflow: a deb 0->1 while pend is already 1 and is not being cleared on that edge drops the coin. pend stays 1, and coin_err=1 for the following cycle. If both channels overflow on the same edge, there is still a single coin_err pulse.
- Output FSM (Moore; outputs decoded from registered state):
  - IDLE: both pulses 0. pend_one -> EMIT_ONE; else pend_half -> EMIT_HALF; else stay in IDLE.
  - EMIT_ONE: piOne=1, one_cnt++ (wraps at 2^CNT_W). Always -> GAP.
  - EMIT_HALF: piHalf=1, half_cnt++ (wraps). Always -> GAP.
  - GAP: both 0. Always -> IDLE.
- Invariants:
  - piOne and piHalf are never 1 in the same cycle.
  - Consecutive pulses are at least 3 cycles apart, start to start.
  - 1-yuan has fixed priority over 0.5-yuan.
- Latency: sampling edge k captures raw=1 into s1 (FSM idle, stable input). deb flips at edge k+1+DEB_CYCLES, and piOne is high in the cycle after edge k+2+DEB_CYCLES. That is 6 edges for the default DEB_CYCLES=4.
- Counters change only in EMIT states. They are never touched by dropped coins.

Test Plan:
- Reset, then clean 1-yuan press (raw high 20 cycles) -> piOne high exactly 1 cycle, 6 edges after the first sampling edge; one_cnt=1; piHalf and coin_err stay 0.
- Bounce: coin_half_raw toggles 1,0,1,0 each cycle, then is held high 10 cycles -> exactly one piHalf pulse, after the stable run completes; half_cnt=1.
- Glitch: coin_one_raw high for 3 cycles (< DEB_CYCLES=4) -> no piOne, one_cnt stays 0.
- Simultaneous: both raw lines rise on the same edge and are held -> piOne in cycle t, piHalf in cycle t+3, never overlapping; both counters=1.
- Overflow: DEB_CYCLES=1, coin_half_raw toggling every 2 cycles while coin_one_raw is held pulsed to keep the FSM busy -> coin_err pulses; half_cnt equals the number of piHalf pulses, not the number of presses.
- Reset mid-flight: assert sysRstN=0 while in EMIT_ONE -> piOne drops immediately, one_cnt=0, pend cleared, and no pulse follows release. Also wrap check: 256 one-yuan coins -> one_cnt wraps to 0.

Source files
------------

// File: rtl/coin_pulse_conditioner.sv
// Coin sensor front end: synchronizes and debounces the 1-yuan and 0.5-yuan lines, then
// serializes accepted coins into mutually exclusive single-cycle piOne/piHalf pulses.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | no pulse; picks next pending coin, 1-yuan first
// ST_EMIT_1  | piOne high, one_cnt advances
// ST_EMIT_H  | piHalf high, half_cnt advances
// ST_GAP     | spacer cycle so pulses start at least 3 apart
module coin_pulse_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             sys_clk,
    input  logic             sysRstN,
    input  logic             coin_one_raw,
    input  logic             coin_half_raw,
    output logic             piOne,
    output logic             piHalf,
    output logic             coin_err,
    output logic [CNT_W-1:0] one_cnt,
    output logic [CNT_W-1:0] half_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EMIT_1 = 2'd1;
    localparam logic [1:0] ST_EMIT_H = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam logic [3:0] DEB_TC = 4'(DEB_CYCLES - 1);

    // channel 0 = 1-yuan, channel 1 = 0.5-yuan
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      deb;
    logic [1:0][3:0] dcnt;
    logic [1:0]      flip;
    logic [1:0]      deb_rise;

    logic       pend_one;
    logic       pend_half;
    logic       clr_one;
    logic       clr_half;
    logic       ovf_one;
    logic       ovf_half;
    logic [1:0] state;
    logic [1:0] state_nxt;

    always_ff @(posedge sys_clk or negedge sysRstN) begin
        if (!sysRstN) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {coin_half_raw, coin_one_raw};
            s2 <= s1;
        end
    end

    always_comb begin
        flip     = '0;
        deb_rise = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i]     = (s2[i] != deb[i]) && (dcnt[i] == DEB_TC);
            deb_rise[i] = flip[i] && s2[i];
        end
    end

    // Any agreeing sample restarts the run, so bounces never accumulate toward a flip.
    always_ff @(posedge sys_clk or negedge sysRstN) begin
        if (!sysRstN) begin
            deb  <= '0;
            dcnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    dcnt[i] <= 4'd0;
                end else if (flip[i]) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= 4'd0;
                end else begin
                    dcnt[i] <= dcnt[i] + 4'd1;
                end
            end
        end
    end

    assign clr_one  = (state == ST_IDLE) && pend_one;
    assign clr_half = (state == ST_IDLE) && !pend_one && pend_half;
    assign ovf_one  = deb_rise[0] && pend_one  && !clr_one;
    assign ovf_half = deb_rise[1] && pend_half && !clr_half;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pend_one)       state_nxt = ST_EMIT_1;
                else if (pend_half) state_nxt = ST_EMIT_H;
                else                state_nxt = ST_IDLE;
            end
            ST_EMIT_1: state_nxt = ST_GAP;
            ST_EMIT_H: state_nxt = ST_GAP;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // A new coin landing on the same edge as the clear must survive, so set beats clear.
    always_ff @(posedge sys_clk or negedge sysRstN) begin
        if (!sysRstN) begin
            state     <= ST_IDLE;
            pend_one  <= 1'b0;
            pend_half <= 1'b0;
            coin_err  <= 1'b0;
            one_cnt   <= '0;
            half_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (deb_rise[0])  pend_one <= 1'b1;
            else if (clr_one) pend_one <= 1'b0;
            if (deb_rise[1])   pend_half <= 1'b1;
            else if (clr_half) pend_half <= 1'b0;
            coin_err <= ovf_one || ovf_half;
            if (state == ST_EMIT_1) one_cnt  <= one_cnt + 1'b1;
            if (state == ST_EMIT_H) half_cnt <= half_cnt + 1'b1;
        end
    end

    assign piOne  = (state == ST_EMIT_1);
    assign piHalf = (state == ST_EMIT_H);

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Directed bench for coin_pulse_conditioner: a default-debounce instance for pulse timing,
// filtering and wrap, and a DEB_CYCLES=1 instance for the pending-overflow path.
module tb_coin_pulse_conditioner;

    typedef struct {
        int one_len;
        int half_len;
        int exp_one;
        int exp_half;
        int lat_one;
        int lat_half;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       sysRstN = 1'b1;
    logic       one_raw0 = 1'b0, half_raw0 = 1'b0;
    logic       one_raw1 = 1'b0, half_raw1 = 1'b0;
    logic       piOne0, piHalf0, err0;
    logic       piOne1, piHalf1, err1;
    logic [7:0] one_cnt0, half_cnt0, one_cnt1, half_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int mon_one0 = 0, mon_half0 = 0, mon_err0 = 0;
    int mon_one1 = 0, mon_half1 = 0, mon_err1 = 0;
    int last_one0 = 0, last_half0 = 0, last_start0 = -100;
    int gap_viol0 = 0, overlap0 = 0, overlap1 = 0;

    vec_t vecs[6];
    int   exp_one_tot  = 0;
    int   exp_half_tot = 0;

    coin_pulse_conditioner #(.DEB_CYCLES(4), .CNT_W(8)) dut0 (
        .sys_clk(sys_clk), .sysRstN(sysRstN),
        .coin_one_raw(one_raw0), .coin_half_raw(half_raw0),
        .piOne(piOne0), .piHalf(piHalf0), .coin_err(err0),
        .one_cnt(one_cnt0), .half_cnt(half_cnt0)
    );

    coin_pulse_conditioner #(.DEB_CYCLES(1), .CNT_W(8)) dut1 (
        .sys_clk(sys_clk), .sysRstN(sysRstN),
        .coin_one_raw(one_raw1), .coin_half_raw(half_raw1),
        .piOne(piOne1), .piHalf(piHalf1), .coin_err(err1),
        .one_cnt(one_cnt1), .half_cnt(half_cnt1)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (piOne0) begin
            mon_one0++;
            last_one0 = cyc;
            if (cyc - last_start0 < 3) gap_viol0++;
            last_start0 = cyc;
        end
        if (piHalf0) begin
            mon_half0++;
            last_half0 = cyc;
            if (cyc - last_start0 < 3) gap_viol0++;
            last_start0 = cyc;
        end
        if (piOne0 && piHalf0) overlap0++;
        if (err0) mon_err0++;
        if (piOne1) mon_one1++;
        if (piHalf1) mon_half1++;
        if (piOne1 && piHalf1) overlap1++;
        if (err1) mon_err1++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n0, so, sh, se;
        @(negedge sys_clk);
        n0 = cyc;
        so = mon_one0; sh = mon_half0; se = mon_err0;
        for (int c = 0; c < 40; c++) begin
            one_raw0  = (c < v.one_len);
            half_raw0 = (c < v.half_len);
            @(negedge sys_clk);
        end
        exp_one_tot  += v.exp_one;
        exp_half_tot += v.exp_half;
        check($sformatf("vec%0d piOne pulses", idx), mon_one0 - so, v.exp_one);
        check($sformatf("vec%0d piHalf pulses", idx), mon_half0 - sh, v.exp_half);
        check($sformatf("vec%0d coin_err pulses", idx), mon_err0 - se, 0);
        check($sformatf("vec%0d one_cnt", idx), int'(one_cnt0), exp_one_tot % 256);
        check($sformatf("vec%0d half_cnt", idx), int'(half_cnt0), exp_half_tot % 256);
        if (v.lat_one != 0)
            check($sformatf("vec%0d piOne latency", idx), last_one0 - n0, v.lat_one);
        if (v.lat_half != 0)
            check($sformatf("vec%0d piHalf latency", idx), last_half0 - n0, v.lat_half);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, so, sh, se, found;

        //            one half eOne eHalf latOne latHalf
        vecs[0] = '{20,  0,  1,  0,  7,  0};   // clean 1-yuan press
        vecs[1] = '{ 3,  0,  0,  0,  0,  0};   // glitch shorter than debounce
        vecs[2] = '{ 4,  0,  1,  0,  7,  0};   // exactly DEB_CYCLES long
        vecs[3] = '{ 0, 20,  0,  1,  0,  7};   // clean 0.5-yuan press
        vecs[4] = '{20, 20,  1,  1,  7, 10};   // simultaneous, 1-yuan first
        vecs[5] = '{ 0,  1,  0,  0,  0,  0};   // single-cycle half glitch

        #2 sysRstN = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset piOne", int'(piOne0), 0);
        check("reset piHalf", int'(piHalf0), 0);
        check("reset coin_err", int'(err0), 0);
        check("reset one_cnt", int'(one_cnt0), 0);
        check("reset half_cnt", int'(half_cnt0), 0);
        check("reset dut1 counts", int'(one_cnt1) + int'(half_cnt1), 0);
        sysRstN = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // bounce 1,0,1,0 then stable high for 10 cycles
        @(negedge sys_clk);
        n0 = cyc; sh = mon_half0;
        for (int c = 0; c < 40; c++) begin
            half_raw0 = (c < 4) ? (c % 2 == 0) : (c < 14);
            @(negedge sys_clk);
        end
        exp_half_tot += 1;
        check("bounce piHalf pulses", mon_half0 - sh, 1);
        check("bounce piHalf latency", last_half0 - n0, 11);
        check("bounce half_cnt", int'(half_cnt0), exp_half_tot % 256);

        // short low dropout inside a held press must not create a second coin
        so = mon_one0;
        for (int c = 0; c < 50; c++) begin
            one_raw0 = (c < 15) || (c >= 17 && c < 27);
            @(negedge sys_clk);
        end
        exp_one_tot += 1;
        check("dropout piOne pulses", mon_one0 - so, 1);
        check("dropout one_cnt", int'(one_cnt0), exp_one_tot % 256);
        check("dut0 coin_err total", mon_err0, 0);

        // overflow: 1-yuan stream keeps the FSM busy while half coins pile up
        so = mon_one1; sh = mon_half1; se = mon_err1;
        for (int c = 0; c < 80; c++) begin
            one_raw1  = (c < 45) && (c % 3 == 0);
            half_raw1 = (c >= 6) && (c < 38) && (((c - 6) % 4) < 2);
            @(negedge sys_clk);
        end
        check("ovf piOne pulses", mon_one1 - so, 15);
        check("ovf one_cnt", int'(one_cnt1), 15);
        check("ovf piHalf pulses", mon_half1 - sh, 1);
        check("ovf half_cnt", int'(half_cnt1), 1);
        check("ovf half_cnt vs pulses", int'(half_cnt1), mon_half1 - sh);
        check("ovf coin_err pulses", mon_err1 - se, 7);
        check("ovf overlap", overlap1, 0);

        // reset asserted while piOne is high
        @(negedge sys_clk);
        one_raw0 = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(posedge sys_clk);
            #1;
            if (piOne0) found = 1;
        end
        check("midflight piOne reached", found, 1);
        sysRstN  = 1'b0;
        one_raw0 = 1'b0;
        #1;
        check("midflight piOne drop", int'(piOne0), 0);
        check("midflight one_cnt", int'(one_cnt0), 0);
        check("midflight half_cnt", int'(half_cnt0), 0);
        repeat (3) @(negedge sys_clk);
        sysRstN = 1'b1;
        so = mon_one0; sh = mon_half0;
        repeat (30) @(negedge sys_clk);
        check("post-reset pulses", (mon_one0 - so) + (mon_half0 - sh), 0);
        check("post-reset one_cnt", int'(one_cnt0), 0);

        // 256 coins wrap the 8-bit counter
        for (int k = 0; k < 256; k++) begin
            for (int c = 0; c < 14; c++) begin
                one_raw0 = (c < 6);
                @(negedge sys_clk);
            end
            if (k == 254) check("wrap one_cnt at 255", int'(one_cnt0), 255);
        end
        check("wrap one_cnt at 256", int'(one_cnt0), 0);

        check("dut0 pulse spacing violations", gap_viol0, 0);
        check("dut0 overlap", overlap0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
